// File: rtl/mem_port_arbiter_if.sv
// Bundle for the fetch/data requester handshakes and the shared memory port.
// ARB_PERF_CNT_EN adds the wait-cycle counter outputs.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 9
);
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_ack;
    logic [31:0]   if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_ack;
    logic [31:0]   dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   if_wait_cnt;
    logic [31:0]   dm_wait_cnt;
`endif

    // Requesters plus memory: drives requests and read data, observes the arbiter.
    modport master (
`ifdef ARB_PERF_CNT_EN
        input  if_wait_cnt, dm_wait_cnt,
`endif
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
`ifdef ARB_PERF_CNT_EN
        output if_wait_cnt, dm_wait_cnt,
`endif
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port word memory with a fixed latency.
// Optional ARB_PERF_CNT_EN adds saturating per-requester wait-cycle counters.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned AW         = 9,
    parameter logic [31:0] DATA_BASE  = 32'h0000_2000,
    parameter int unsigned MAX_STREAK = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned SW = $clog2(MAX_STREAK + 1);
    localparam logic [CW-1:0] LastCnt    = CW'(MEM_LAT - 1);
    // Wraps to all-ones when MEM_LAT==1, a value the counter never holds then.
    localparam logic [CW-1:0] PreLastCnt = CW'(MEM_LAT - 2);
    localparam logic [SW-1:0] MaxStreak  = SW'(MAX_STREAK);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] streak_q;
    logic          dm_sel_q;
    logic          we_q;
    logic          if_ack_q, dm_ack_q;
    logic [31:0]   if_rdata_q, dm_rdata_q;
    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic          busy_q;

    logic [31:0]   dm_off;
    logic [AW-1:0] if_word, dm_word;
    logic          grant_dm;

    assign dm_off   = bus.dm_addr - DATA_BASE;
    assign if_word  = bus.if_addr[AW+1:2];
    assign dm_word  = dm_off[AW+1:2];
    assign grant_dm = bus.dm_req && (!bus.if_req || (streak_q < MaxStreak));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            streak_q    <= '0;
            dm_sel_q    <= 1'b0;
            we_q        <= 1'b0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.if_req || bus.dm_req) begin
                        state_q     <= StAccess;
                        cnt_q       <= '0;
                        dm_sel_q    <= grant_dm;
                        we_q        <= grant_dm && bus.dm_we;
                        mem_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        mem_addr_q  <= grant_dm ? dm_word : if_word;
                        mem_wdata_q <= grant_dm ? bus.dm_wdata : '0;
                        mem_we_q    <= (MEM_LAT == 1) && grant_dm && bus.dm_we;
                        streak_q    <= (grant_dm && bus.if_req) ? streak_q + 1'b1 : '0;
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q  <= StDone;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (dm_sel_q) begin
                            dm_ack_q   <= 1'b1;
                            dm_rdata_q <= we_q ? 32'h0 : bus.mem_rdata;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        // Registered strobe: raise it one cycle ahead of the last access cycle.
                        mem_we_q <= we_q && (cnt_q == PreLastCnt);
                    end
                end
                StDone: begin
                    if_ack_q <= 1'b0;
                    dm_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_wait_q, dm_wait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_wait_q <= '0;
            dm_wait_q <= '0;
        end else begin
            if (bus.if_req && !if_ack_q && (if_wait_q != 32'hFFFF_FFFF)) begin
                if_wait_q <= if_wait_q + 32'd1;
            end
            if (bus.dm_req && !dm_ack_q && (dm_wait_q != 32'hFFFF_FFFF)) begin
                dm_wait_q <= dm_wait_q + 32'd1;
            end
        end
    end

    assign bus.if_wait_cnt = if_wait_q;
    assign bus.dm_wait_cnt = dm_wait_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port word memory between the instruction-fetch requester (read-only) and the data-memory requester (read/write) of the MIPS pipeline.
- Sequences each access over a fixed memory latency and returns data with a one-cycle ack.
- Pipeline stall logic derives stalls from req-high/ack-low.
- Data accesses have priority, with a starvation guard that protects fetch.

Parameters:
- MEM_LAT, 2, memory access cycles per transaction (>=1).
- AW, 9, memory word-address width.
- DATA_BASE, 32'h0000_2000, byte address mapped to memory word 0 for data accesses.
- MAX_STREAK, 4, consecutive data grants allowed while fetch is waiting (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  32  fetch data, valid while if_ack.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  write data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  32  read data, valid while dm_ack (0 for writes).
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid by end of the MEM_LAT-th access cycle.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; latency counter 0; streak 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: arbitrate, latch grant/addr/we/wdata, go to ACCESS with counter=0.
- Arbitration:
  - dm wins if streak<MAX_STREAK.
  - Else, if if_req is high, fetch wins.
  - A lone requester always wins.
- Streak update:
  - Data grant with if_req high: streak+1.
  - Data grant with if_req low: streak cleared.
  - Fetch grant: streak cleared.
- ACCESS:
  - mem_en=1; mem_addr/mem_wdata from the latched values for the whole state.
  - Counter increments each cycle.
  - Last cycle (counter==MEM_LAT-1): mem_we=latched we (exactly one write pulse); mem_rdata registered into the granted requester's rdata; next state DONE.
- DONE:
  - Granted ack=1 for exactly one cycle with rdata; then IDLE unconditionally.
  - Never two acks in consecutive cycles.
- Latency:
  - Request seen in IDLE at cycle 0 -> ACCESS cycles 1..MEM_LAT -> ack at cycle MEM_LAT+1.
  - Throughput: one access per MEM_LAT+2 cycles.
- Address rules:
  - Fetch: mem_addr=if_addr[AW+1:2].
  - Data: mem_addr=((dm_addr-DATA_BASE)>>2)[AW-1:0].
  - Low two bits ignored; out-of-range addresses wrap modulo 2^AW.
- Inputs change mid-transaction: ignored (values latched at grant).
- Req dropped before ack: access still completes and ack still pulses.
- rdata holds its last value between acks.
- Reset mid-operation: immediate return to IDLE; outputs 0; no write pulse; transaction discarded; streak 0.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs if_wait_cnt[31:0] and dm_wait_cnt[31:0].
  - Each counts cycles where its req=1 and its ack=0.
  - Saturates at 32'hFFFF_FFFF; reset 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Single fetch (MEM_LAT=2): if_addr=0x8, mem word2=0xDEADBEEF -> mem_en with mem_addr=2 in cycles 1-2; if_ack in cycle 3 with if_rdata=0xDEADBEEF; busy high cycles 1-3.
- Data write: dm_addr=0x2010, dm_wdata=0x1234 -> mem_addr=4; mem_we high only in cycle 2; mem_wdata=0x1234; dm_ack in cycle 3; dm_rdata=0.
- Simultaneous requests at cycle 0 (both new) -> dm granted first (ack cycle 3); fetch granted in cycle 4 (ack cycle 7).
- if_req and dm_req held high continuously (each re-requests after its ack), MAX_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- rst asserted in cycle 1 of a write with MEM_LAT=3 -> mem_we never pulses; memory unchanged; all outputs 0; busy 0; after release a new fetch completes normally.
- With ARB_PERF_CNT_EN, lone fetch, MEM_LAT=2 -> if_wait_cnt=3 after ack; dm_wait_cnt=0.
